// File: rtl/mips_defs.sv
// mips_defs: opcode, funct, ALU control, aluop and FSM state encodings for the MIPS controllers
package mips_defs;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPEEX, ALUWB, BEQEX, ADDIEX, ADDIWB, JEX
  } state_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: (aluop_i, funct_i) -> alucontrol_o; unlisted funct or aluop decodes to add
module alu_decoder
  import mips_defs::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);
  always_comb begin
    alucontrol_o = aluop_i == AOP_SUB ? ALU_SUB :
                   aluop_i != AOP_FN  ? ALU_ADD :
                   funct_i == FN_SUB  ? ALU_SUB :
                   funct_i == FN_AND  ? ALU_AND :
                   funct_i == FN_OR   ? ALU_OR  :
                   funct_i == FN_SLT  ? ALU_SLT : ALU_ADD;
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing multicycle MIPS; in clk/reset/opcode/funct/zero, out datapath selects, write enables, alucontrol
module mips_multicycle_control
  import mips_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc
);
  state_t     state_q, state_d;
  logic       pcwrite, branch;
  logic [1:0] aluop;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                         opcode == OP_R    ? RTYPEEX :
                         opcode == OP_BEQ  ? BEQEX :
                         opcode == OP_ADDI ? ADDIEX :
                         opcode == OP_J    ? JEX : FETCH;
      MEMADR:  state_d = opcode == OP_SW ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end
  // reset gates every write enable so nothing commits while reset is held
  always_comb begin
    pcwrite  = state_q == FETCH || state_q == JEX;
    branch   = state_q == BEQEX;
    irwrite  = !reset && state_q == FETCH;
    memwrite = !reset && state_q == MEMWR;
    regwrite = !reset && (state_q == MEMWB || state_q == ALUWB || state_q == ADDIWB);
    pcen     = !reset && (pcwrite || (branch && zero));
    iord     = state_q == MEMRD || state_q == MEMWR;
    regdst   = state_q == ALUWB;
    memtoreg = state_q == MEMWB;
    alusrca  = state_q == MEMADR || state_q == RTYPEEX || state_q == BEQEX || state_q == ADDIEX;
    alusrcb  = state_q == FETCH  ? 2'b01 :
               state_q == DECODE ? 2'b11 :
               (state_q == MEMADR || state_q == ADDIEX) ? 2'b10 : 2'b00;
    aluop    = state_q == RTYPEEX ? AOP_FN : state_q == BEQEX ? AOP_SUB : AOP_ADD;
    pcsrc    = state_q == BEQEX ? 2'b01 : state_q == JEX ? 2'b10 : 2'b00;
  end
  alu_decoder u_alu_decoder (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle control unit for the 32-bit datapath: a Moore state machine that sequences fetch, decode, execute, memory and write-back for one instruction at a time. It produces every datapath select and write enable, including the 3-bit ALU control code. It consumes the ALU `zero` flag to resolve branches. It sits between the instruction register (opcode/funct fields) and the datapath muxes, register file, memory and PC register.

## Interface
Parameters: none. All encodings are fixed constants.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `opcode`  in  6  instr[31:26] from the instruction register
- `funct`  in  6  instr[5:0] from the instruction register
- `zero`  in  1  ALU equality flag (a == b)
- `pcen`  out  1  PC register enable
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result register
- `memwrite`  out  1  data memory write enable
- `irwrite`  out  1  instruction register write enable
- `regdst`  out  1  destination register select: 0 = rt, 1 = rd
- `memtoreg`  out  1  write-back data select: 0 = ALU result, 1 = memory data
- `regwrite`  out  1  register file write enable
- `alusrca`  out  1  ALU operand a select: 0 = PC, 1 = register A
- `alusrcb`  out  2  ALU operand b select: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- `alucontrol`  out  3  ALU operation code
- `pcsrc`  out  2  next-PC select: 00 = ALU, 01 = ALU result register, 10 = jump target

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, ALUWB, BEQEX, ADDIEX, ADDIWB, JEX. State is held in a 4-bit register.
- Opcodes:
  - lw = 100011
  - sw = 101011
  - R-type = 000000
  - beq = 000100
  - addi = 001000
  - j = 000010
- ALU control codes:
  - and = 000
  - or = 001
  - add = 010
  - sub = 110
  - slt = 111
  - Bit 2 means "invert b, carry-in 1".
- Funct to ALU op (R-type only):
  - 100000 → add
  - 100010 → sub
  - 100100 → and
  - 100101 → or
  - 101010 → slt
  - Any other funct → add.
- Internal aluop: 00 = add, 01 = sub, 10 = use funct.
- Outputs per state. Every output not listed is 0; `alucontrol` not listed is add.
  - FETCH: irwrite=1, alusrcb=01, pcwrite=1.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- `pcen` = pcwrite | (branch & zero).
- Transitions:
  - FETCH→DECODE.
  - DECODE by opcode: lw/sw→MEMADR, R→RTYPEEX, beq→BEQEX, addi→ADDIEX, j→JEX, unknown→FETCH (instruction treated as NOP; PC already advanced).
  - MEMADR→MEMRD (lw) or MEMWR (sw).
  - MEMRD→MEMWB.
  - RTYPEEX→ALUWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BEQEX, ADDIWB, JEX→FETCH.
- `opcode` is sampled only in DECODE and MEMADR; `funct` only in RTYPEEX. The instruction register holds both stable after FETCH.

## Timing
- Reset (asynchronous assert) forces state to FETCH immediately.
- While `reset`=1, `pcen`, `irwrite`, `memwrite` and `regwrite` are forced to 0. All other outputs show their FETCH values: iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00, regdst=0, memtoreg=0.
- First FETCH cycle executes on the first rising edge after `reset` deasserts.
- Outputs are combinational from the state register, except `pcen`, which also depends on `zero` in BEQEX.
- Cycles per instruction:
  - lw = 5
  - sw = 4
  - R-type = 4
  - addi = 4
  - beq = 3
  - j = 3
  - unknown = 2
- Reset asserted mid-instruction abandons the instruction. No partial write completes after the asserting edge.

## Structure
- Shared package/header `mips_defs`: opcode constants, funct constants, ALU control codes, aluop codes, state encodings.
- One sub-module, `alu_decoder`: combinational (aluop, funct) → alucontrol. It is reused by any future single-cycle controller.
- The FSM, output decode and `pcen` logic live in `mips_multicycle_control`.

## Test plan
- Reset held 3 cycles, then released → write enables 0 during reset, alusrcb=01; first post-reset cycle irwrite=1, pcen=1.
- opcode=100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in cycle 5; back to FETCH in cycle 6.
- opcode=000000 with funct=101010, then funct=100010 → alucontrol=111 in RTYPEEX, then 110; regdst=1, regwrite=1 in ALUWB.
- opcode=000100 with zero=1, then zero=0 → pcen=1 with pcsrc=01 in BEQEX for zero=1; pcen=0 for zero=0; alucontrol=110 in both.
- opcode=101011, then opcode=111111 → memwrite=1 with iord=1 only in cycle 4; unknown opcode returns to FETCH after DECODE (2 cycles) with no write enable asserted.
- Reset asserted during MEMWR of sw → memwrite drops to 0 immediately; state is FETCH after reset release.
